mem_wb_loadext: RTL and testbench

Memory-to-writeback stage of the P8 pipelined MIPS core. It sits directly downstream of the data memory. Each cycle it takes the raw 32-bit word read from data memory, together with the byte offset of the access. It extracts and sign- or zero-extends the addressed byte, halfword or word, checks load alignment, and registers the result with the destination register, PC and valid bit into the writeback stage. The block supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/mem_wb_loadext.sv | 144 ++++++++++++++
 tb/tb_mem_wb_loadext.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_wb_loadext.sv
// Memory-to-writeback pipeline register for the P8 MIPS core.
// It extends load data and checks load alignment, then registers the result with stall and flush control.
module mem_wb_loadext #(
   parameter logic [31:0] RESET_PC = 32'h00003000
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        M_Valid,
   input  logic [2:0]  M_LoadOp,
   input  logic [1:0]  M_LoadSelect,
   input  logic [31:0] M_DOUT,
   input  logic [31:0] M_ALUResult,
   input  logic        M_RegWr,
   input  logic [4:0]  M_WriteReg,
   input  logic [31:0] M_PC,
   output logic        W_Valid,
   output logic        W_RegWr,
   output logic [4:0]  W_WriteReg,
   output logic [31:0] W_WriteData,
   output logic [31:0] W_PC,
   output logic        W_AdEL,
   output logic [31:0] W_BadVAddr
);

   typedef enum logic [2:0] {
      LD_LW  = 3'b000,
      LD_LB  = 3'b001,
      LD_LBU = 3'b010,
      LD_LH  = 3'b011,
      LD_LHU = 3'b100
   } load_op_e;

   logic        valid_q, valid_d;
   logic        regwr_q, regwr_d;
   logic [4:0]  write_reg_q, write_reg_d;
   logic [31:0] write_data_q, write_data_d;
   logic [31:0] pc_q, pc_d;
   logic        adel_q, adel_d;
   logic [31:0] bad_vaddr_q, bad_vaddr_d;

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] ext_data;
   logic        misaligned;
   logic        adel;
   logic        regwr;

   // Lane extraction, extension and alignment check
   always_comb begin
      byte_lane  = '0;
      half_lane  = '0;
      ext_data   = M_ALUResult;
      misaligned = 1'b0;

      case (M_LoadSelect)
         2'b00:   byte_lane = M_DOUT[7:0];
         2'b01:   byte_lane = M_DOUT[15:8];
         2'b10:   byte_lane = M_DOUT[23:16];
         default: byte_lane = M_DOUT[31:24];
      endcase
      half_lane = M_LoadSelect[1] ? M_DOUT[31:16] : M_DOUT[15:0];

      case (load_op_e'(M_LoadOp))
         LD_LW: begin
            ext_data   = M_DOUT;
            misaligned = (M_LoadSelect != 2'b00);
         end
         LD_LB:  ext_data = {{24{byte_lane[7]}}, byte_lane};
         LD_LBU: ext_data = {24'h000000, byte_lane};
         LD_LH: begin
            ext_data   = {{16{half_lane[15]}}, half_lane};
            misaligned = M_LoadSelect[0];
         end
         LD_LHU: begin
            ext_data   = {16'h0000, half_lane};
            misaligned = M_LoadSelect[0];
         end
         default: ext_data = M_ALUResult;
      endcase

      adel  = M_Valid & misaligned;
      regwr = M_Valid & M_RegWr & ~adel & (M_WriteReg != 5'd0);
   end

   // Next-state selection; a flush beats a stall, and reset is applied in the flop block
   always_comb begin
      valid_d      = valid_q;
      regwr_d      = regwr_q;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      pc_d         = pc_q;
      adel_d       = adel_q;
      bad_vaddr_d  = bad_vaddr_q;

      if (Flush) begin
         valid_d      = 1'b0;
         regwr_d      = 1'b0;
         write_reg_d  = '0;
         write_data_d = '0;
         pc_d         = RESET_PC;
         adel_d       = 1'b0;
         bad_vaddr_d  = '0;
      end else if (!Stall) begin
         valid_d      = M_Valid;
         regwr_d      = regwr;
         write_reg_d  = M_WriteReg;
         write_data_d = adel ? '0 : ext_data;
         pc_d         = M_PC;
         adel_d       = adel;
         bad_vaddr_d  = adel ? M_ALUResult : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         valid_q      <= 1'b0;
         regwr_q      <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         pc_q         <= RESET_PC;
         adel_q       <= 1'b0;
         bad_vaddr_q  <= '0;
      end else begin
         valid_q      <= valid_d;
         regwr_q      <= regwr_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         pc_q         <= pc_d;
         adel_q       <= adel_d;
         bad_vaddr_q  <= bad_vaddr_d;
      end
   end

   assign W_Valid     = valid_q;
   assign W_RegWr     = regwr_q;
   assign W_WriteReg  = write_reg_q;
   assign W_WriteData = write_data_q;
   assign W_PC        = pc_q;
   assign W_AdEL      = adel_q;
   assign W_BadVAddr  = bad_vaddr_q;

endmodule

// File: tb/tb_mem_wb_loadext.sv
// Directed bench for mem_wb_loadext: a table of vectors followed by stall, flush and reset sequences.
module tb_mem_wb_loadext;

   logic        clk = 1'b0;
   logic        Reset, Stall, Flush;
   logic        M_Valid, M_RegWr;
   logic [2:0]  M_LoadOp;
   logic [1:0]  M_LoadSelect;
   logic [31:0] M_DOUT, M_ALUResult, M_PC;
   logic [4:0]  M_WriteReg;
   logic        W_Valid, W_RegWr, W_AdEL;
   logic [4:0]  W_WriteReg;
   logic [31:0] W_WriteData, W_PC, W_BadVAddr;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   localparam logic [31:0] RST_PC = 32'h00003000;
   localparam logic [31:0] D      = 32'h80FF7F01;

   mem_wb_loadext #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
      .M_Valid(M_Valid), .M_LoadOp(M_LoadOp), .M_LoadSelect(M_LoadSelect),
      .M_DOUT(M_DOUT), .M_ALUResult(M_ALUResult), .M_RegWr(M_RegWr),
      .M_WriteReg(M_WriteReg), .M_PC(M_PC),
      .W_Valid(W_Valid), .W_RegWr(W_RegWr), .W_WriteReg(W_WriteReg),
      .W_WriteData(W_WriteData), .W_PC(W_PC), .W_AdEL(W_AdEL),
      .W_BadVAddr(W_BadVAddr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  sel;
      logic        valid;
      logic        regwr;
      logic [4:0]  wreg;
      logic [31:0] dout;
      logic [31:0] alu;
      logic [31:0] pc;
      logic        e_valid;
      logic        e_regwr;
      logic [31:0] e_data;
      logic        e_adel;
      logic [31:0] e_bad;
   } vec_t;

   localparam int NV = 16;
   vec_t vec [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input logic v, input logic r, input logic [4:0] wr,
                          input logic [31:0] d, input logic [31:0] pc, input logic a,
                          input logic [31:0] b);
      chk({tag, ".valid"}, {31'd0, W_Valid}, {31'd0, v});
      chk({tag, ".regwr"}, {31'd0, W_RegWr}, {31'd0, r});
      chk({tag, ".wreg"},  {27'd0, W_WriteReg}, {27'd0, wr});
      chk({tag, ".data"},  W_WriteData, d);
      chk({tag, ".pc"},    W_PC, pc);
      chk({tag, ".adel"},  {31'd0, W_AdEL}, {31'd0, a});
      chk({tag, ".bad"},   W_BadVAddr, b);
   endtask

   task automatic drive(input logic [2:0] op, input logic [1:0] sel, input logic v, input logic r,
                        input logic [4:0] wr, input logic [31:0] dout, input logic [31:0] alu,
                        input logic [31:0] pc);
      M_LoadOp = op; M_LoadSelect = sel; M_Valid = v; M_RegWr = r;
      M_WriteReg = wr; M_DOUT = dout; M_ALUResult = alu; M_PC = pc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            op    sel    v  r  wreg   dout          alu           pc            ev er e_data        ea e_bad
      vec[0]  = '{3'd1, 2'd0, 1, 1, 5'd5, D,            32'h00000100, 32'h00400000, 1, 1, 32'h00000001, 0, 32'h0};
      vec[1]  = '{3'd1, 2'd2, 1, 1, 5'd5, D,            32'h00000102, 32'h00400004, 1, 1, 32'hFFFFFFFF, 0, 32'h0};
      vec[2]  = '{3'd2, 2'd3, 1, 1, 5'd5, D,            32'h00000103, 32'h00400008, 1, 1, 32'h00000080, 0, 32'h0};
      vec[3]  = '{3'd3, 2'd2, 1, 1, 5'd5, D,            32'h00000102, 32'h0040000C, 1, 1, 32'hFFFF80FF, 0, 32'h0};
      vec[4]  = '{3'd4, 2'd0, 1, 1, 5'd5, D,            32'h00000100, 32'h00400010, 1, 1, 32'h00007F01, 0, 32'h0};
      vec[5]  = '{3'd0, 2'd0, 1, 1, 5'd5, D,            32'h00000100, 32'h00400014, 1, 1, 32'h80FF7F01, 0, 32'h0};
      vec[6]  = '{3'd0, 2'd2, 1, 1, 5'd5, D,            32'h00000106, 32'h00400018, 1, 0, 32'h00000000, 1, 32'h00000106};
      vec[7]  = '{3'd3, 2'd1, 1, 1, 5'd5, D,            32'h00000106, 32'h0040001C, 1, 0, 32'h00000000, 1, 32'h00000106};
      vec[8]  = '{3'd4, 2'd3, 1, 1, 5'd7, D,            32'h0000010B, 32'h00400020, 1, 0, 32'h00000000, 1, 32'h0000010B};
      vec[9]  = '{3'd1, 2'd3, 1, 1, 5'd7, D,            32'h0000010B, 32'h00400024, 1, 1, 32'hFFFFFF80, 0, 32'h0};
      vec[10] = '{3'd0, 2'd0, 1, 1, 5'd0, D,            32'h00000100, 32'h00400028, 1, 0, 32'h80FF7F01, 0, 32'h0};
      vec[11] = '{3'd7, 2'd3, 1, 1, 5'd9, 32'hDEADBEEF, 32'h12345678, 32'h0040002C, 1, 1, 32'h12345678, 0, 32'h0};
      vec[12] = '{3'd5, 2'd0, 1, 1, 5'd0, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00400030, 1, 0, 32'hCAFEF00D, 0, 32'h0};
      vec[13] = '{3'd0, 2'd2, 0, 1, 5'd5, D,            32'h00000106, 32'h00400034, 0, 0, 32'h80FF7F01, 0, 32'h0};
      vec[14] = '{3'd3, 2'd2, 1, 0, 5'd5, D,            32'h00000102, 32'h00400038, 1, 0, 32'hFFFF80FF, 0, 32'h0};
      vec[15] = '{3'd6, 2'd1, 1, 1, 5'd3, D,            32'h00000001, 32'h0040003C, 1, 1, 32'h00000001, 0, 32'h0};

      Stall = 0; Flush = 0; Reset = 0;
      drive(3'($urandom), 2'($urandom), 1'b1, 1'b1, 5'($urandom), $urandom, $urandom, $urandom);
      step();
      drive(3'($urandom), 2'($urandom), 1'b1, 1'b1, 5'($urandom), $urandom, $urandom, $urandom);
      step();
      chk_all("reset", 0, 0, 5'd0, 32'h0, RST_PC, 0, 32'h0);
      Reset = 1;

      for (int i = 0; i < NV; i++) begin
         drive(vec[i].op, vec[i].sel, vec[i].valid, vec[i].regwr, vec[i].wreg,
               vec[i].dout, vec[i].alu, vec[i].pc);
         step();
         chk_all($sformatf("vec%0d", i), vec[i].e_valid, vec[i].e_regwr, vec[i].wreg,
                 vec[i].e_data, vec[i].pc, vec[i].e_adel, vec[i].e_bad);
      end

      // Instruction A, then three stalled cycles with different M inputs
      drive(3'd0, 2'd0, 1, 1, 5'd12, 32'hA5A50001, 32'h00000200, 32'h00401000);
      step();
      chk_all("capA", 1, 1, 5'd12, 32'hA5A50001, 32'h00401000, 0, 32'h0);
      Stall = 1;
      for (int k = 0; k < 3; k++) begin
         drive(3'd0, 2'd1, 1, 1, 5'(k + 20), 32'h11110000 + 32'(k), 32'h00000301, 32'h00402000 + 32'(k));
         step();
         chk_all($sformatf("stall%0d", k), 1, 1, 5'd12, 32'hA5A50001, 32'h00401000, 0, 32'h0);
      end
      Flush = 1;
      step();
      chk_all("stall_flush", 0, 0, 5'd0, 32'h0, RST_PC, 0, 32'h0);
      Stall = 0; Flush = 0;
      drive(3'd2, 2'd1, 1, 1, 5'd14, 32'h0000C300, 32'h00000401, 32'h00403000);
      step();
      chk_all("after_flush", 1, 1, 5'd14, 32'h000000C3, 32'h00403000, 0, 32'h0);

      // Flush alone, then reset asserted together with stall and flush
      drive(3'd0, 2'd0, 1, 1, 5'd15, 32'h01020304, 32'h00000500, 32'h00404000);
      Flush = 1;
      step();
      chk_all("flush_only", 0, 0, 5'd0, 32'h0, RST_PC, 0, 32'h0);
      Flush = 0;
      step();
      chk_all("cap_b", 1, 1, 5'd15, 32'h01020304, 32'h00404000, 0, 32'h0);
      Reset = 0; Stall = 1; Flush = 1;
      step();
      chk_all("reset_mid", 0, 0, 5'd0, 32'h0, RST_PC, 0, 32'h0);
      Reset = 1; Stall = 0; Flush = 0;
      drive(3'd4, 2'd2, 1, 1, 5'd16, 32'hBEEF0000, 32'h00000602, 32'h00405000);
      step();
      chk_all("reset_release", 1, 1, 5'd16, 32'h0000BEEF, 32'h00405000, 0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
